// File: rtl/dec_prf_freelist.sv
// -----------------------------------------------------------------------------
// dec_prf_freelist
// Free list of physical register (PRF) codes for the rename stage. It is a
// circular buffer with two head pointers and one tail:
//   spec_head - next entry handed out to rename (advances on allocation)
//   cmt_head  - committed head, used to restore spec_head on a flush
//   tail      - next entry written by a release from commit
// Each pointer carries a wrap bit above the index bits, so full and empty are
// distinguishable.
//
// Ports
//   clk                      clock, all state changes on the rising edge
//   rst_n                    synchronous active-low reset
//   i_fl_alloc_req_0..3      rename slot k needs a destination PRF (0 oldest)
//   i_fl_alloc_fire          decode group advances this cycle
//   o_fl_alloc_rdy           enough free entries for every requesting slot
//   o_fl_alloc_prf_code_0..3 PRF code for slot k (valid when its req is set)
//   i_fl_rls_vld_0..3        commit slot k frees a previous mapping
//   i_fl_rls_prf_code_0..3   freed PRF code
//   i_fl_except_flush        pipeline flush, restores spec_head
//   o_fl_free_cnt            number of free entries, 0..FL_DEPTH
// -----------------------------------------------------------------------------
module dec_prf_freelist #(
   parameter int PRF_NUM        = 64,
   parameter int ARF_NUM        = 32,
   parameter int PRF_CODE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_fl_alloc_req_0,
   input  logic                      i_fl_alloc_req_1,
   input  logic                      i_fl_alloc_req_2,
   input  logic                      i_fl_alloc_req_3,
   input  logic                      i_fl_alloc_fire,
   output logic                      o_fl_alloc_rdy,
   output logic [PRF_CODE_WIDTH-1:0] o_fl_alloc_prf_code_0,
   output logic [PRF_CODE_WIDTH-1:0] o_fl_alloc_prf_code_1,
   output logic [PRF_CODE_WIDTH-1:0] o_fl_alloc_prf_code_2,
   output logic [PRF_CODE_WIDTH-1:0] o_fl_alloc_prf_code_3,
   input  logic                      i_fl_rls_vld_0,
   input  logic                      i_fl_rls_vld_1,
   input  logic                      i_fl_rls_vld_2,
   input  logic                      i_fl_rls_vld_3,
   input  logic [PRF_CODE_WIDTH-1:0] i_fl_rls_prf_code_0,
   input  logic [PRF_CODE_WIDTH-1:0] i_fl_rls_prf_code_1,
   input  logic [PRF_CODE_WIDTH-1:0] i_fl_rls_prf_code_2,
   input  logic [PRF_CODE_WIDTH-1:0] i_fl_rls_prf_code_3,
   input  logic                      i_fl_except_flush,
   output logic [PRF_CODE_WIDTH-1:0] o_fl_free_cnt
);

   localparam int FL_DEPTH = PRF_NUM - ARF_NUM;
   localparam int IDX_W    = $clog2(FL_DEPTH);
   localparam int PTR_W    = IDX_W + 1;

   logic [PRF_CODE_WIDTH-1:0] entry_q [FL_DEPTH];
   logic [PTR_W-1:0]          spec_head_q, spec_head_d;
   logic [PTR_W-1:0]          cmt_head_q, cmt_head_d;
   logic [PTR_W-1:0]          tail_q, tail_d;
   logic [PTR_W-1:0]          free_cnt;

   logic [3:0]                req;
   logic [3:0]                vld;
   logic [PRF_CODE_WIDTH-1:0] rls_code   [4];
   logic [PRF_CODE_WIDTH-1:0] alloc_code [4];
   logic [2:0]                alloc_off  [4];
   logic [2:0]                rls_off    [4];
   logic [IDX_W-1:0]          alloc_idx  [4];
   logic [IDX_W-1:0]          rls_idx    [4];
   logic [2:0]                n_alloc;
   logic [2:0]                n_rls;
   logic                      alloc_rdy;
   logic                      do_alloc;

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   assign req = {i_fl_alloc_req_3, i_fl_alloc_req_2, i_fl_alloc_req_1, i_fl_alloc_req_0};
   assign vld = {i_fl_rls_vld_3, i_fl_rls_vld_2, i_fl_rls_vld_1, i_fl_rls_vld_0};
   assign rls_code[0] = i_fl_rls_prf_code_0;
   assign rls_code[1] = i_fl_rls_prf_code_1;
   assign rls_code[2] = i_fl_rls_prf_code_2;
   assign rls_code[3] = i_fl_rls_prf_code_3;

   assign n_alloc  = popcnt4(req);
   assign n_rls    = popcnt4(vld);

   // Wrap-bit arithmetic: the difference is exact for 0..FL_DEPTH.
   assign free_cnt = tail_q - spec_head_q;

   // Flush kills allocation in the same cycle, so rdy drops with it.
   assign alloc_rdy = (free_cnt >= PTR_W'(n_alloc)) && !i_fl_except_flush;
   assign do_alloc  = i_fl_alloc_fire && alloc_rdy;

   // Slot k's offset is the number of set bits in the older slots, so the
   // grants (and the release writes) are compacted with no holes.
   for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      localparam logic [3:0] OLDER = 4'((1 << gi) - 1);

      assign alloc_off[gi]  = popcnt4(req & OLDER);
      assign rls_off[gi]    = popcnt4(vld & OLDER);
      assign alloc_idx[gi]  = spec_head_q[IDX_W-1:0] + IDX_W'(alloc_off[gi]);
      assign rls_idx[gi]    = tail_q[IDX_W-1:0] + IDX_W'(rls_off[gi]);
      assign alloc_code[gi] = entry_q[alloc_idx[gi]];

      a_no_rls_code0 : assert property (@(posedge clk) disable iff (!rst_n)
         !(vld[gi] && (rls_code[gi] == '0)));
   end

   a_no_overfill : assert property (@(posedge clk) disable iff (!rst_n)
      (32'(free_cnt) + 32'(n_rls)) <= FL_DEPTH);

   always_comb begin
      tail_d      = tail_q + PTR_W'(n_rls);
      cmt_head_d  = cmt_head_q + PTR_W'(n_rls);
      spec_head_d = spec_head_q;
      if (i_fl_except_flush) begin
         // Restore to the committed head including this cycle's release.
         spec_head_d = cmt_head_d;
      end else if (do_alloc) begin
         spec_head_d = spec_head_q + PTR_W'(n_alloc);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spec_head_q <= '0;
         cmt_head_q  <= '0;
         tail_q      <= PTR_W'(FL_DEPTH);
         for (int i = 0; i < FL_DEPTH; i++) begin
            entry_q[i] <= PRF_CODE_WIDTH'(ARF_NUM + i);
         end
      end else begin
         spec_head_q <= spec_head_d;
         cmt_head_q  <= cmt_head_d;
         tail_q      <= tail_d;
         for (int k = 0; k < 4; k++) begin
            if (vld[k]) begin
               entry_q[rls_idx[k]] <= rls_code[k];
            end
         end
      end
   end

   assign o_fl_alloc_rdy        = alloc_rdy;
   assign o_fl_alloc_prf_code_0 = alloc_code[0];
   assign o_fl_alloc_prf_code_1 = alloc_code[1];
   assign o_fl_alloc_prf_code_2 = alloc_code[2];
   assign o_fl_alloc_prf_code_3 = alloc_code[3];
   assign o_fl_free_cnt         = PRF_CODE_WIDTH'(free_cnt);

endmodule

// File: tb/tb_dec_prf_freelist.sv
// -----------------------------------------------------------------------------
// tb_dec_prf_freelist
// Directed test of the PRF free list: reset state, sparse allocation,
// draining to empty, release at empty, flush restore (alone and with a
// release), concurrent alloc/release and reset mid-operation. Expected values
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dec_prf_freelist;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       fire;
   logic [3:0] vld;
   logic [5:0] rls_code [4];
   logic       flush;
   logic       rdy;
   logic [5:0] code0, code1, code2, code3;
   logic [5:0] free_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   dec_prf_freelist dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .i_fl_alloc_req_0      (req[0]),
      .i_fl_alloc_req_1      (req[1]),
      .i_fl_alloc_req_2      (req[2]),
      .i_fl_alloc_req_3      (req[3]),
      .i_fl_alloc_fire       (fire),
      .o_fl_alloc_rdy        (rdy),
      .o_fl_alloc_prf_code_0 (code0),
      .o_fl_alloc_prf_code_1 (code1),
      .o_fl_alloc_prf_code_2 (code2),
      .o_fl_alloc_prf_code_3 (code3),
      .i_fl_rls_vld_0        (vld[0]),
      .i_fl_rls_vld_1        (vld[1]),
      .i_fl_rls_vld_2        (vld[2]),
      .i_fl_rls_vld_3        (vld[3]),
      .i_fl_rls_prf_code_0   (rls_code[0]),
      .i_fl_rls_prf_code_1   (rls_code[1]),
      .i_fl_rls_prf_code_2   (rls_code[2]),
      .i_fl_rls_prf_code_3   (rls_code[3]),
      .i_fl_except_flush     (flush),
      .o_fl_free_cnt         (free_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_codes(input string tag, input int c0, input int c1, input int c2, input int c3);
      check_val({tag, ".code0"}, 32'(code0), 32'(c0));
      check_val({tag, ".code1"}, 32'(code1), 32'(c1));
      check_val({tag, ".code2"}, 32'(code2), 32'(c2));
      check_val({tag, ".code3"}, 32'(code3), 32'(c3));
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req   = 4'b0000;
      fire  = 1'b0;
      vld   = 4'b0000;
      flush = 1'b0;
      for (int k = 0; k < 4; k++) rls_code[k] = 6'd0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      step();
      rst_n = 1'b1;
   endtask

   task automatic fire4(input int n);
      for (int c = 0; c < n; c++) begin
         req  = 4'b1111;
         fire = 1'b1;
         step();
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      step();
      step();
      rst_n = 1'b1;

      // Reset state with all four slots requesting
      req = 4'b1111; #1;
      check_val("rst.rdy", 32'(rdy), 32'd1);
      check_val("rst.free", 32'(free_cnt), 32'd32);
      check_codes("rst", 32, 33, 34, 35);
      $display("[TB] reset state checked");

      // Sparse request: slots 0 and 2
      req = 4'b0101; fire = 1'b1; #1;
      check_val("sparse.rdy", 32'(rdy), 32'd1);
      check_val("sparse.code0", 32'(code0), 32'd32);
      check_val("sparse.code2", 32'(code2), 32'd33);
      step();
      idle(); req = 4'b0001; #1;
      check_val("sparse.free", 32'(free_cnt), 32'd30);
      check_val("sparse.next_code0", 32'(code0), 32'd34);
      $display("[TB] sparse allocation checked");

      // Drain to empty with eight 4-wide fires
      do_reset();
      fire4(8);
      check_val("empty.free", 32'(free_cnt), 32'd0);
      req = 4'b0001; #1;
      check_val("empty.rdy1", 32'(rdy), 32'd0);
      req = 4'b1111; fire = 1'b1; #1;
      check_val("empty.rdy4", 32'(rdy), 32'd0);
      step();
      idle(); #1;
      check_val("empty.fire_ignored", 32'(free_cnt), 32'd0);
      check_val("empty.rdy0", 32'(rdy), 32'd1);
      $display("[TB] empty list checked");

      // Release codes 5 and 7 on slots 1 and 3 while empty
      vld = 4'b1010; rls_code[1] = 6'd5; rls_code[3] = 6'd7;
      step();
      idle(); #1;
      check_val("rls.free", 32'(free_cnt), 32'd2);
      req = 4'b1111; #1;
      check_val("rls.rdy4", 32'(rdy), 32'd0);
      req = 4'b0011; #1;
      check_val("rls.rdy2", 32'(rdy), 32'd1);
      check_val("rls.code0", 32'(code0), 32'd5);
      check_val("rls.code1", 32'(code1), 32'd7);
      $display("[TB] release at empty checked");

      // Allocate 12, release 1..4, then flush
      do_reset();
      fire4(3);
      check_val("flush.free_a", 32'(free_cnt), 32'd20);
      vld = 4'b1111;
      for (int k = 0; k < 4; k++) rls_code[k] = 6'(k + 1);
      step();
      idle(); #1;
      check_val("flush.free_r", 32'(free_cnt), 32'd24);
      flush = 1'b1; req = 4'b1111; fire = 1'b1; #1;
      check_val("flush.rdy", 32'(rdy), 32'd0);
      step();
      idle(); req = 4'b1111; #1;
      check_val("flush.free", 32'(free_cnt), 32'd32);
      check_codes("flush", 36, 37, 38, 39);
      $display("[TB] flush restore checked");

      // Flush in the same cycle as a release of two codes
      do_reset();
      fire4(2);
      flush = 1'b1; vld = 4'b0011; rls_code[0] = 6'd10; rls_code[1] = 6'd11;
      step();
      idle(); req = 4'b1111; #1;
      check_val("flushrls.free", 32'(free_cnt), 32'd32);
      check_codes("flushrls", 34, 35, 36, 37);
      $display("[TB] flush with release checked");

      // Allocation and release in the same cycle
      do_reset();
      fire4(1);
      req = 4'b1111; fire = 1'b1; vld = 4'b0001; rls_code[0] = 6'd9; #1;
      check_val("both.rdy", 32'(rdy), 32'd1);
      check_val("both.code0", 32'(code0), 32'd36);
      step();
      idle(); #1;
      check_val("both.free", 32'(free_cnt), 32'd25);
      $display("[TB] concurrent alloc/release checked");

      // Reset asserted during fire and release
      rst_n = 1'b0;
      req = 4'b1111; fire = 1'b1; vld = 4'b0001; rls_code[0] = 6'd20;
      step();
      rst_n = 1'b1;
      idle(); req = 4'b1111; #1;
      check_val("midrst.free", 32'(free_cnt), 32'd32);
      check_val("midrst.rdy", 32'(rdy), 32'd1);
      check_codes("midrst", 32, 33, 34, 35);
      $display("[TB] reset mid-operation checked");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
